knn_majority_vote: RTL and testbench



---
 rtl/knn_pkg.sv | 27 ++
 rtl/knn_majority_vote.sv | 154 +++++++++++++++
 tb/tb_knn_majority_vote.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/knn_pkg.sv
// knn_pkg: constants and types shared by the KNN pipeline blocks.
//   K            - neighbour labels held by the top-K list (rank 0 = nearest)
//   LABEL_W      - label width in bits
//   NUM_CLASSES  - number of classes (2**LABEL_W)
//   CNT_W        - width of vote counters and rank indices; wide enough to
//                  hold K itself, which serves as the "no rank yet" sentinel
package knn_pkg;

  localparam int K           = 5;
  localparam int LABEL_W     = 2;
  localparam int NUM_CLASSES = 4;
  localparam int CNT_W       = $clog2(K + 1);

  typedef logic [LABEL_W-1:0] label_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    RESOLVE
  } state_e;

  localparam cnt_t RANK_SENTINEL = cnt_t'(K);
  localparam cnt_t IDX_LAST      = cnt_t'(K - 1);
  localparam cnt_t CLS_LAST      = cnt_t'(NUM_CLASSES - 1);

endpackage

// File: rtl/knn_majority_vote.sv
// knn_majority_vote: majority vote over the K nearest neighbour labels.
// On an accepted start the label list is captured, votes are tallied one rank
// per cycle (K cycles), then classes are scanned one per cycle (NUM_CLASSES
// cycles) to pick the winner. Ties go to the class whose nearest member has
// the lowest rank. The result is presented with a one-cycle valid pulse.
// Ports:
//   clk        - clock
//   rst        - synchronous active-high reset
//   start      - vote request, sampled only while idle
//   labels_in  - K packed labels, rank 0 in the least significant field
//   busy       - high while a vote is in progress
//   valid      - one-cycle pulse, class_out/vote_count updated
//   class_out  - predicted class, held until the next result
//   vote_count - votes received by the predicted class
module knn_majority_vote
  import knn_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [K*LABEL_W-1:0]   labels_in,
  output logic                   busy,
  output logic                   valid,
  output logic [LABEL_W-1:0]     class_out,
  output logic [CNT_W-1:0]       vote_count
);

  state_e           state_q, state_d;
  label_t [K-1:0]   labels_q, labels_d;
  cnt_t             cnt_q [NUM_CLASSES];
  cnt_t             cnt_d [NUM_CLASSES];
  cnt_t             first_rank_q [NUM_CLASSES];
  cnt_t             first_rank_d [NUM_CLASSES];
  cnt_t             idx_q, idx_d;
  cnt_t             best_cnt_q, best_cnt_d;
  cnt_t             best_rank_q, best_rank_d;
  label_t           best_cls_q, best_cls_d;
  label_t           class_q, class_d;
  cnt_t             vcnt_q, vcnt_d;
  logic             valid_q, valid_d;

  // idx walks ranks in COUNT and classes in RESOLVE.
  label_t cur_lbl;
  label_t res_cls;
  logic   take_res;

  assign cur_lbl  = labels_q[idx_q];
  assign res_cls  = label_t'(idx_q);
  // A zero-vote class can only tie a zero best, and its sentinel rank is
  // never below the sentinel best_rank, so it never wins.
  assign take_res = (cnt_q[res_cls] > best_cnt_q) ||
                    ((cnt_q[res_cls] == best_cnt_q) &&
                     (first_rank_q[res_cls] < best_rank_q));

  always_comb begin
    state_d      = state_q;
    labels_d     = labels_q;
    cnt_d        = cnt_q;
    first_rank_d = first_rank_q;
    idx_d        = idx_q;
    best_cnt_d   = best_cnt_q;
    best_rank_d  = best_rank_q;
    best_cls_d   = best_cls_q;
    class_d      = class_q;
    vcnt_d       = vcnt_q;
    valid_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          labels_d = labels_in;
          for (int c = 0; c < NUM_CLASSES; c++) begin
            cnt_d[c]        = '0;
            first_rank_d[c] = RANK_SENTINEL;
          end
          idx_d   = '0;
          state_d = COUNT;
        end
      end

      COUNT: begin
        cnt_d[cur_lbl] = cnt_q[cur_lbl] + cnt_t'(1);
        if (first_rank_q[cur_lbl] == RANK_SENTINEL) begin
          first_rank_d[cur_lbl] = idx_q;
        end
        if (idx_q == IDX_LAST) begin
          idx_d       = '0;
          best_cnt_d  = '0;
          best_rank_d = RANK_SENTINEL;
          best_cls_d  = '0;
          state_d     = RESOLVE;
        end else begin
          idx_d = idx_q + cnt_t'(1);
        end
      end

      RESOLVE: begin
        if (take_res) begin
          best_cnt_d  = cnt_q[res_cls];
          best_rank_d = first_rank_q[res_cls];
          best_cls_d  = res_cls;
        end
        if (idx_q == CLS_LAST) begin
          // Publish from the already-updated best so the last class counts.
          class_d = best_cls_d;
          vcnt_d  = best_cnt_d;
          valid_d = 1'b1;
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + cnt_t'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      labels_q    <= '0;
      idx_q       <= '0;
      best_cnt_q  <= '0;
      best_rank_q <= RANK_SENTINEL;
      best_cls_q  <= '0;
      class_q     <= '0;
      vcnt_q      <= '0;
      valid_q     <= 1'b0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        cnt_q[c]        <= '0;
        first_rank_q[c] <= RANK_SENTINEL;
      end
    end else begin
      state_q      <= state_d;
      labels_q     <= labels_d;
      idx_q        <= idx_d;
      best_cnt_q   <= best_cnt_d;
      best_rank_q  <= best_rank_d;
      best_cls_q   <= best_cls_d;
      class_q      <= class_d;
      vcnt_q       <= vcnt_d;
      valid_q      <= valid_d;
      cnt_q        <= cnt_d;
      first_rank_q <= first_rank_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign valid      = valid_q;
  assign class_out  = class_q;
  assign vote_count = vcnt_q;

endmodule

// File: tb/tb_knn_majority_vote.sv
// tb_knn_majority_vote: directed and randomized votes checked against a
// behavioural majority model (max count, ties to the nearest-ranked label).
module tb_knn_majority_vote;
  import knn_pkg::*;

  localparam int LW  = K * LABEL_W;
  localparam int LAT = K + NUM_CLASSES + 1;

  logic              clk;
  logic              rst;
  logic              start;
  logic [LW-1:0]     labels_in;
  logic              busy;
  logic              valid;
  logic [LABEL_W-1:0] class_out;
  logic [CNT_W-1:0]  vote_count;

  int checks   = 0;
  int failures = 0;
  int last_cls = 0;
  int last_cnt = 0;

  knn_majority_vote dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .labels_in  (labels_in),
    .busy       (busy),
    .valid      (valid),
    .class_out  (class_out),
    .vote_count (vote_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] pack5(input int r0, input int r1, input int r2,
                                          input int r3, input int r4);
    int r[5];
    logic [LW-1:0] v;
    r[0] = r0; r[1] = r1; r[2] = r2; r[3] = r3; r[4] = r4;
    v = '0;
    for (int i = 0; i < K; i++) v[i*LABEL_W +: LABEL_W] = LABEL_W'(r[i]);
    return v;
  endfunction

  // Winner = label of the nearest rank whose class holds the maximum count.
  task automatic model(input logic [LW-1:0] lbl, output int cls, output int cnt);
    int votes[NUM_CLASSES];
    int mx;
    foreach (votes[c]) votes[c] = 0;
    for (int r = 0; r < K; r++) votes[int'(lbl[r*LABEL_W +: LABEL_W])]++;
    mx = 0;
    foreach (votes[c]) if (votes[c] > mx) mx = votes[c];
    cls = -1;
    for (int r = 0; r < K; r++) begin
      if (cls < 0 && votes[int'(lbl[r*LABEL_W +: LABEL_W])] == mx)
        cls = int'(lbl[r*LABEL_W +: LABEL_W]);
    end
    cnt = mx;
  endtask

  // Called at a negedge; the start raised here is sampled at the next edge.
  task automatic do_vote(input logic [LW-1:0] lbl, input bit disturb);
    int ec, en;
    model(lbl, ec, en);
    labels_in = lbl;
    start     = 1'b1;
    for (int cyc = 1; cyc <= LAT; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start = 1'b0;
        if (!disturb) labels_in = LW'($urandom);
      end
      if (disturb && cyc == 3) labels_in = '0;
      if (disturb && cyc == 4) start = 1'b1;
      if (disturb && cyc == 5) start = 1'b0;
      if (cyc < LAT) begin
        check($sformatf("busy_c%0d", cyc), int'(busy), 1);
        check($sformatf("valid_early_c%0d", cyc), int'(valid), 0);
      end else begin
        check("valid_at_latency", int'(valid), 1);
        check("busy_in_valid_cycle", int'(busy), 0);
        check("class_out", int'(class_out), ec);
        check("vote_count", int'(vote_count), en);
      end
    end
    last_cls = ec;
    last_cnt = en;
    $display("vote labels=%h exp_class=%0d exp_count=%0d got_class=%0d got_count=%0d",
             lbl, ec, en, class_out, vote_count);
  endtask

  task automatic idle_check;
    @(negedge clk);
    check("valid_pulse_one_cycle", int'(valid), 0);
    check("busy_idle", int'(busy), 0);
    check("class_held", int'(class_out), last_cls);
    check("count_held", int'(vote_count), last_cnt);
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    start     = 1'b0;
    labels_in = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_class", int'(class_out), 0);
    check("reset_count", int'(vote_count), 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    do_vote(pack5(1, 1, 2, 3, 1), 1'b0);
    idle_check();
    do_vote(pack5(2, 3, 3, 2, 0), 1'b0);
    idle_check();
    do_vote(pack5(3, 0, 0, 3, 1), 1'b0);
    idle_check();
    do_vote(pack5(2, 2, 2, 2, 2), 1'b0);
    idle_check();
    // Label change and ignored start mid-vote, then a back-to-back start.
    do_vote(pack5(1, 1, 2, 3, 1), 1'b1);
    do_vote(pack5(3, 3, 3, 0, 0), 1'b0);
    idle_check();

    // Reset in cycle 5 of a vote.
    labels_in = pack5(1, 1, 2, 3, 1);
    start     = 1'b1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(valid), 0);
    check("abort_class", int'(class_out), 0);
    check("abort_count", int'(vote_count), 0);
    rst  = 1'b0;
    seen = 0;
    for (int cyc = 0; cyc < 2 * LAT; cyc++) begin
      @(negedge clk);
      if (valid) seen++;
    end
    check("abort_no_valid", seen, 0);
    do_vote(pack5(0, 2, 2, 1, 0), 1'b0);
    idle_check();

    // rst and start together: no vote starts.
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("rst_start_busy0", int'(busy), 0);
    @(negedge clk);
    check("rst_start_busy1", int'(busy), 0);
    check("rst_start_valid", int'(valid), 0);

    // Randomized votes with random idle gaps (gap 0 = back-to-back).
    for (int n = 0; n < 40; n++) begin
      do_vote(LW'($urandom), 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) idle_check();
    end
    idle_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
